// File: rtl/irq_event_pkg.sv
// Shared types and constants for the interrupt event controller.
// The priority encoder and the top level both import this package.
package irq_event_pkg;

  localparam int IRQ_ID_W = 5;
  localparam int IRQ_LINES = 32;

  localparam logic [1:0] IRQ_REG_MASK = 2'd0;
  localparam logic [1:0] IRQ_REG_PEND = 2'd1;
  localparam logic [1:0] IRQ_REG_SET  = 2'd2;
  localparam logic [1:0] IRQ_REG_RSVD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } irq_state_e;

  // One-hot decode of a line ID, used to clear the acknowledged pending bit.
  function automatic logic [IRQ_LINES-1:0] id_onehot(input logic [IRQ_ID_W-1:0] id);
    return {{(IRQ_LINES-1){1'b0}}, 1'b1} << id;
  endfunction

endpackage

// File: rtl/irq_event_ctrl_prio_enc.sv
// Combinational 32-to-5 priority encoder: the highest set index wins.
// valid is low when no request bit is set; id is then 0.
module irq_prio_enc
  import irq_event_pkg::*;
(
  input  logic [IRQ_LINES-1:0] req,
  output logic [IRQ_ID_W-1:0]  id,
  output logic                 valid
);

  // Later iterations overwrite earlier ones, so the highest set index remains.
  always_comb begin
    id = '0;
    for (int i = 0; i < IRQ_LINES; i++) begin
      if (req[i]) begin
        id = IRQ_ID_W'(i);
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/irq_event_ctrl.sv
// Interrupt event controller: rising-edge capture into a pending register,
// masking, highest-index selection and a level request/ack handshake to the core.
module irq_event_ctrl
  import irq_event_pkg::*;
#(
  parameter int                N_IRQ      = 32,
  parameter logic [N_IRQ-1:0]  MASK_RESET = 32'hFFFF_FFFF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_IRQ-1:0]    irq_lines_i,
  output logic                irq_o,
  output logic [IRQ_ID_W-1:0] irq_id_o,
  input  logic                irq_ack_i,
  input  logic [IRQ_ID_W-1:0] irq_ack_id_i,
  input  logic                cfg_we_i,
  input  logic [1:0]          cfg_addr_i,
  input  logic [N_IRQ-1:0]    cfg_wdata_i,
  output logic [N_IRQ-1:0]    cfg_rdata_o
);

  logic [N_IRQ-1:0]    lines_q;
  logic [N_IRQ-1:0]    pend_q;
  logic [N_IRQ-1:0]    mask_q;
  logic [N_IRQ-1:0]    edge_vec;
  logic [N_IRQ-1:0]    eligible;
  logic [N_IRQ-1:0]    pend_clr;
  logic [N_IRQ-1:0]    pend_set;
  logic [N_IRQ-1:0]    pend_d;
  logic                pend_wr;
  logic                set_wr;
  logic                mask_wr;
  logic                ack_take;
  logic                sel_valid;
  logic [IRQ_ID_W-1:0] sel_id;
  logic [IRQ_ID_W-1:0] id_q;
  logic [IRQ_ID_W-1:0] id_d;
  logic                irq_q;
  irq_state_e          state_q;
  irq_state_e          state_d;

  assign pend_wr = cfg_we_i && (cfg_addr_i == IRQ_REG_PEND);
  assign set_wr  = cfg_we_i && (cfg_addr_i == IRQ_REG_SET);
  assign mask_wr = cfg_we_i && (cfg_addr_i == IRQ_REG_MASK);

  assign edge_vec = irq_lines_i & ~lines_q;
  assign eligible = pend_q & mask_q;

  irq_prio_enc u_prio_enc (
    .req   (eligible),
    .id    (sel_id),
    .valid (sel_valid)
  );

  // Set sources are applied after clears, so a new event survives a same-cycle clear.
  always_comb begin
    pend_clr = '0;
    pend_set = edge_vec;
    if (pend_wr) begin
      pend_clr = pend_clr | cfg_wdata_i;
    end
    if (ack_take) begin
      pend_clr = pend_clr | id_onehot(irq_ack_id_i);
    end
    if (set_wr) begin
      pend_set = pend_set | cfg_wdata_i;
    end
    pend_d = (pend_q & ~pend_clr) | pend_set;
  end

  // The ID is captured only on entry to REQ so the core sees a stable value.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    ack_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          id_d    = sel_id;
          state_d = REQ;
        end
      end
      REQ: begin
        if (irq_ack_i) begin
          ack_take = 1'b1;
          state_d  = WAIT;
        end else if (!eligible[id_q]) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      id_q    <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      irq_q   <= (state_d == REQ);
    end
  end

  // lines_q clears on reset so a line held high through reset raises an event afterwards.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lines_q <= '0;
      pend_q  <= '0;
      mask_q  <= MASK_RESET;
    end else begin
      lines_q <= irq_lines_i;
      pend_q  <= pend_d;
      if (mask_wr) begin
        mask_q <= cfg_wdata_i;
      end
    end
  end

  always_comb begin
    cfg_rdata_o = '0;
    case (cfg_addr_i)
      IRQ_REG_MASK: cfg_rdata_o = mask_q;
      IRQ_REG_PEND: cfg_rdata_o = pend_q;
      default:      cfg_rdata_o = '0;
    endcase
  end

  assign irq_o    = irq_q;
  assign irq_id_o = id_q;

endmodule
